// File: rtl/conv_8x32_comp_pkg.sv
// Shared types and the compare rule for the multi-lane min/max reducer.
// Optional per-lane index tracking is enabled with the CONV_COMP_INDEX_EN macro.
package conv_8x32_comp_pkg;

   localparam int CONV_DATA_WIDTH = 8;
   localparam int CONV_LANES      = 4;
   localparam int CONV_DEPTH      = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef enum logic {
      CMP_MIN = 1'b0,
      CMP_MAX = 1'b1
   } cmp_mode_t;

   // True when a is strictly better than b; equality never wins, so ties keep the earlier beat.
   function automatic logic better(input logic [CONV_DATA_WIDTH-1:0] a,
                                   input logic [CONV_DATA_WIDTH-1:0] b,
                                   input cmp_mode_t                  mode,
                                   input logic                       signed_en);
      logic gt;
      logic lt;
      if (signed_en) begin
         gt = ($signed(a) > $signed(b));
         lt = ($signed(a) < $signed(b));
      end else begin
         gt = (a > b);
         lt = (a < b);
      end
      return (mode == CMP_MAX) ? gt : lt;
   endfunction

endpackage

// File: rtl/conv_8x32_comp_lane.sv
// One reduction lane: holds the running extreme value (and, with CONV_COMP_INDEX_EN,
// the beat index where it was seen) and updates it on each accepted beat.
module conv_8x32_comp_lane
   import conv_8x32_comp_pkg::*;
#(
   parameter int DATA_WIDTH = CONV_DATA_WIDTH
`ifdef CONV_COMP_INDEX_EN
   ,
   parameter int IDX_W      = $clog2(CONV_DEPTH)
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic                  upd,
   input  logic                  mode_max,
   input  logic                  signed_en,
   input  logic [DATA_WIDTH-1:0] din,
`ifdef CONV_COMP_INDEX_EN
   input  logic [IDX_W-1:0]      idx_in,
   output logic [IDX_W-1:0]      idx_out,
`endif
   output logic [DATA_WIDTH-1:0] val_out
);

   logic [DATA_WIDTH-1:0] val_q, val_d;
   logic                  take;

   always_comb begin
      take  = load | (upd & better(din, val_q, cmp_mode_t'(mode_max), signed_en));
      val_d = val_q;
      if (take) begin
         val_d = din;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign val_out = val_q;

`ifdef CONV_COMP_INDEX_EN
   logic [IDX_W-1:0] idx_q, idx_d;

   always_comb begin
      idx_d = idx_q;
      if (take) begin
         idx_d = idx_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign idx_out = idx_q;
`endif

endmodule

// File: rtl/conv_8x32_comp_reduce.sv
// Streaming multi-lane min/max reducer: one result per frame of LANES-wide beats.
// Define CONV_COMP_INDEX_EN to add per-lane winning-beat indices on m_idx.
module conv_8x32_comp_reduce
   import conv_8x32_comp_pkg::*;
#(
   parameter  int DATA_WIDTH = CONV_DATA_WIDTH,
   parameter  int LANES      = CONV_LANES,
   parameter  int DEPTH      = CONV_DEPTH,
   localparam int IDX_W      = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [LANES*DATA_WIDTH-1:0] s_data,
   input  logic                        s_last,
   input  logic                        cfg_max,
   input  logic                        cfg_signed,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [LANES*DATA_WIDTH-1:0] m_data,
`ifdef CONV_COMP_INDEX_EN
   output logic [LANES*IDX_W-1:0]      m_idx,
`endif
   output logic                        m_ovf
);

   // Handshake: a beat transfers on a clk edge where s_valid & s_ready, a result
   // on an edge where m_valid & m_ready; neither valid may depend on its ready.
   state_t           state_q, state_d;
   logic             ready_q, ready_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   cmp_mode_t        mode_q, mode_d;
   logic             signed_q, signed_d;

   logic             accept;
   logic             first;
   logic             upd;
   logic             sat;
   logic [IDX_W-1:0] idx_cur;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      mode_d   = mode_q;
      signed_d = signed_q;

      accept  = s_valid & ready_q;
      first   = accept & (state_q == IDLE);
      upd     = accept & (state_q == ACC);
      // The first beat of a frame is always index 0, whatever the counter holds.
      idx_cur = (state_q == IDLE) ? '0 : cnt_q;
      sat     = (idx_cur == IDX_W'(DEPTH - 1));

      if (accept) begin
         cnt_d = sat ? idx_cur : idx_cur + 1'b1;
      end

      // A saturated-index beat that is not last means the frame has more than DEPTH beats.
      if (first) begin
         mode_d   = cmp_mode_t'(cfg_max);
         signed_d = cfg_signed;
         ovf_d    = sat & ~s_last;
      end else if (upd) begin
         ovf_d = ovf_q | (sat & ~s_last);
      end

      case (state_q)
         IDLE: if (accept) state_d = s_last ? HOLD : ACC;
         ACC:  if (accept && s_last) state_d = HOLD;
         HOLD: if (m_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      ready_d = (state_d != HOLD);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ready_q  <= 1'b0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         mode_q   <= CMP_MIN;
         signed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ready_q  <= ready_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         mode_q   <= mode_d;
         signed_q <= signed_d;
      end
   end

   assign s_ready = ready_q;
   assign m_valid = (state_q == HOLD);
   assign m_ovf   = ovf_q;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      conv_8x32_comp_lane #(
         .DATA_WIDTH (DATA_WIDTH)
`ifdef CONV_COMP_INDEX_EN
         ,
         .IDX_W      (IDX_W)
`endif
      ) u_lane (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (first),
         .upd       (upd),
         .mode_max  (mode_q == CMP_MAX),
         .signed_en (signed_q),
         .din       (s_data[k*DATA_WIDTH +: DATA_WIDTH]),
`ifdef CONV_COMP_INDEX_EN
         .idx_in    (idx_cur),
         .idx_out   (m_idx[k*IDX_W +: IDX_W]),
`endif
         .val_out   (m_data[k*DATA_WIDTH +: DATA_WIDTH])
      );
   end

endmodule

// File: tb/tb_conv_8x32_comp_reduce.sv
// Bench for conv_8x32_comp_reduce: directed scenarios plus random frames against a
// per-frame reference model; index checks are active when CONV_COMP_INDEX_EN is defined.
module tb_conv_8x32_comp_reduce;

   localparam int W    = 8;
   localparam int L    = 4;
   localparam int D    = 32;
   localparam int IW   = 5;
   localparam int TMO  = 200;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            s_valid;
   logic            s_ready;
   logic [L*W-1:0]  s_data;
   logic            s_last;
   logic            cfg_max;
   logic            cfg_signed;
   logic            m_valid;
   logic            m_ready;
   logic [L*W-1:0]  m_data;
   logic [L*IW-1:0] m_idx;
   logic            m_ovf;

   int n_assert = 0;
   int n_fail   = 0;

   logic [L*W-1:0]  frame_data [0:63];
   logic [L*W-1:0]  exp_q[$];
   logic [L*IW-1:0] exp_idx_q[$];
   logic            exp_ovf_q[$];
   logic [L*W-1:0]  snap;

   conv_8x32_comp_reduce dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .cfg_max    (cfg_max),
      .cfg_signed (cfg_signed),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
`ifdef CONV_COMP_INDEX_EN
      .m_idx      (m_idx),
`endif
      .m_ovf      (m_ovf)
   );

`ifndef CONV_COMP_INDEX_EN
   assign m_idx = '0;
`endif

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: observed no end of test, required finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_int(input logic [W-1:0] x, input logic sg);
      return sg ? {{24{x[W-1]}}, x} : {24'b0, x};
   endfunction

   // reference model: result of a whole frame from the reduction rules
   task automatic model_frame(input int len, input logic mx, input logic sg);
      logic [L*W-1:0]  ed;
      logic [L*IW-1:0] ei;
      for (int k = 0; k < L; k++) begin
         int best;
         int bidx;
         int v;
         best = to_int(frame_data[0][k*W +: W], sg);
         bidx = 0;
         for (int b = 1; b < len; b++) begin
            v = to_int(frame_data[b][k*W +: W], sg);
            if (mx ? (v > best) : (v < best)) begin
               best = v;
               bidx = (b > D - 1) ? D - 1 : b;
            end
         end
         ed[k*W +: W]   = best[W-1:0];
         ei[k*IW +: IW] = bidx[IW-1:0];
      end
      exp_q.push_back(ed);
      exp_idx_q.push_back(ei);
      exp_ovf_q.push_back(len > D);
   endtask

   // driver tasks
   task automatic fill_random(input int len, input int maxv);
      for (int b = 0; b < len; b++) begin
         for (int k = 0; k < L; k++) begin
            frame_data[b][k*W +: W] = W'($urandom_range(0, maxv));
         end
      end
   endtask

   task automatic drive_beat(input logic [L*W-1:0] d, input logic last,
                             input logic mx, input logic sg);
      int waited;
      waited     = 0;
      s_valid    = 1'b1;
      s_data     = d;
      s_last     = last;
      cfg_max    = mx;
      cfg_signed = sg;
      while (s_ready !== 1'b1 && waited < TMO) begin
         @(posedge clk); #1;
         waited++;
      end
      check("s_ready_wait", 64'(waited < TMO), 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_frame(input int len, input logic mx, input logic sg,
                             input logic scramble, input logic gaps, input logic push);
      logic bm;
      logic bs;
      for (int b = 0; b < len; b++) begin
         bm = mx;
         bs = sg;
         if (b > 0 && scramble) begin
            bm = 1'($urandom_range(0, 1));
            bs = 1'($urandom_range(0, 1));
         end
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         drive_beat(frame_data[b], (b == len - 1), bm, bs);
      end
      if (push) model_frame(len, mx, sg);
   endtask

   task automatic wait_valid();
      int waited;
      waited = 0;
      while (m_valid !== 1'b1 && waited < TMO) begin
         @(posedge clk); #1;
         waited++;
      end
      check("m_valid_wait", 64'(waited < TMO), 64'd1);
   endtask

   // scoreboard
   task automatic check_result(input string tag);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd1);
      end else begin
         logic [L*W-1:0]  ed;
         logic [L*IW-1:0] ei;
         logic            eo;
         ed = exp_q.pop_front();
         ei = exp_idx_q.pop_front();
         eo = exp_ovf_q.pop_front();
         check({tag, "_data"}, 64'(m_data), 64'(ed));
`ifdef CONV_COMP_INDEX_EN
         check({tag, "_idx"}, 64'(m_idx), 64'(ei));
`endif
         check({tag, "_ovf"}, 64'(m_ovf), 64'(eo));
      end
   endtask

   task automatic release_result(input int hold);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      cfg_max    = 1'b0;
      cfg_signed = 1'b0;
      m_ready    = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_m_valid", 64'(m_valid), 64'd0);
      check("rst_m_data",  64'(m_data),  64'd0);
      check("rst_m_ovf",   64'(m_ovf),   64'd0);
`ifdef CONV_COMP_INDEX_EN
      check("rst_m_idx",   64'(m_idx),   64'd0);
`endif
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_release_s_ready", 64'(s_ready), 64'd1);

      // T1: unsigned max with a tie on lane 0
      fill_random(3, 255);
      frame_data[0][7:0] = 8'd5;
      frame_data[1][7:0] = 8'd9;
      frame_data[2][7:0] = 8'd9;
      send_frame(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_valid();
      check_result("t1");
      check("t1_lane0_val", 64'(m_data[7:0]), 64'd9);
`ifdef CONV_COMP_INDEX_EN
      check("t1_lane0_idx", 64'(m_idx[4:0]), 64'd1);
`endif
      release_result(0);

      // T2: signed vs unsigned min on lane 1
      fill_random(3, 255);
      frame_data[0][15:8] = 8'h7F;
      frame_data[1][15:8] = 8'h80;
      frame_data[2][15:8] = 8'h01;
      send_frame(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      wait_valid();
      check_result("t2s");
      check("t2s_lane1_val", 64'(m_data[15:8]), 64'h80);
`ifdef CONV_COMP_INDEX_EN
      check("t2s_lane1_idx", 64'(m_idx[9:5]), 64'd1);
`endif
      release_result(1);
      send_frame(3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_valid();
      check_result("t2u");
      check("t2u_lane1_val", 64'(m_data[15:8]), 64'h01);
`ifdef CONV_COMP_INDEX_EN
      check("t2u_lane1_idx", 64'(m_idx[9:5]), 64'd2);
`endif
      release_result(0);

      // T3: single-beat frame, result one cycle after acceptance
      fill_random(1, 255);
      check("t3_m_valid_before", 64'(m_valid), 64'd0);
      send_frame(1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check("t3_m_valid_latency", 64'(m_valid), 64'd1);
      check("t3_values", 64'(m_data), 64'(frame_data[0]));
      check_result("t3");
      release_result(0);

      // T4: backpressure on the result
      fill_random(4, 255);
      send_frame(4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      wait_valid();
      snap = m_data;
      s_valid = 1'b1;
      s_data  = '1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check("t4_s_ready_low", 64'(s_ready), 64'd0);
         check("t4_m_valid_held", 64'(m_valid), 64'd1);
         check("t4_m_data_stable", 64'(m_data), 64'(snap));
      end
      s_valid = 1'b0;
      check_result("t4");
      release_result(0);
      check("t4_m_valid_drop", 64'(m_valid), 64'd0);
      check("t4_s_ready_back", 64'(s_ready), 64'd1);

      // T5: overflow frame, then boundary frames
      fill_random(34, 100);
      frame_data[33] = '1;
      send_frame(34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_valid();
      check_result("t5_ovf");
      check("t5_ovf_flag", 64'(m_ovf), 64'd1);
      check("t5_lane0_val", 64'(m_data[7:0]), 64'hFF);
`ifdef CONV_COMP_INDEX_EN
      check("t5_lane0_idx", 64'(m_idx[4:0]), 64'd31);
`endif
      release_result(0);
      fill_random(5, 255);
      send_frame(5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_valid();
      check("t5_ovf_cleared", 64'(m_ovf), 64'd0);
      check_result("t5_next");
      release_result(0);
      for (int n = 32; n <= 33; n++) begin
         fill_random(n, 255);
         send_frame(n, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
         wait_valid();
         check_result("t5_edge");
         release_result(0);
      end

      // T6: reset mid-frame, then a fresh 1-beat frame
      fill_random(2, 255);
      frame_data[0] = '1;
      frame_data[1] = '1;
      drive_beat(frame_data[0], 1'b0, 1'b1, 1'b0);
      drive_beat(frame_data[1], 1'b0, 1'b1, 1'b0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("t6_rst_s_ready", 64'(s_ready), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      fill_random(1, 100);
      send_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_valid();
      check_result("t6");
      release_result(0);

      // reset while a result is pending
      fill_random(1, 255);
      send_frame(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      wait_valid();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("hold_rst_m_valid", 64'(m_valid), 64'd0);
      check("hold_rst_m_data", 64'(m_data), 64'd0);
      @(posedge clk); #1;

      // random frames: varied length, cfg, tie density, gaps and mid-frame cfg noise
      for (int f = 0; f < 24; f++) begin
         int len;
         logic mx;
         logic sg;
         len = $urandom_range(1, 40);
         mx  = 1'($urandom_range(0, 1));
         sg  = 1'($urandom_range(0, 1));
         fill_random(len, (f % 2 == 0) ? 7 : 255);
         send_frame(len, mx, sg, 1'b1, 1'b1, 1'b1);
         wait_valid();
         check_result("rand");
         release_result($urandom_range(0, 3));
      end

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
